// File: rtl/adc_axis_packetizer.sv
// ADC stream packetizer: re-frames tlast-delimited chirp bursts into bounded
// packets, each a single header beat followed by up to MAX_PAYLOAD_WORDS payload
// beats. The output side is one register stage, so there is no combinational
// path from s_axis to m_axis.
module adc_axis_packetizer #(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned MAX_PAYLOAD_WORDS = 256,
    parameter logic [15:0] MAGIC             = 16'hA5C3
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      enable,
    input  logic                      clear_counters,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tuser,
    input  logic                      m_axis_tready,
    output logic [31:0]               pkt_count
);

    localparam logic [15:0] LastBeat = 16'(MAX_PAYLOAD_WORDS - 1);

    typedef enum logic [0:0] {StIdle, StPayload} state_e;

    state_e      state_q, state_d;
    logic [15:0] seq_q, chirp_q, beat_cnt_q;
    logic        first_q;
    logic        ld, hdr_load, beat_acc, end_pkt;
    logic [63:0] header;

    // The output register may take a new beat when it is empty or being drained.
    assign ld           = !m_axis_tvalid || m_axis_tready;
    assign header       = {MAGIC, 7'b0, first_q, 8'h00, chirp_q, seq_q};
    assign m_axis_tkeep = '1;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a header opens a packet, the ending payload beat closes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (hdr_load) state_d = StPayload;
            StPayload: if (end_pkt)  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs: input handshake and the header/payload/end-of-packet strobes.
    always_comb begin
        s_axis_tready = 1'b0;
        hdr_load      = 1'b0;
        beat_acc      = 1'b0;
        end_pkt       = 1'b0;
        unique case (state_q)
            StIdle: begin
                // The waiting input word only triggers the header; it is not consumed.
                hdr_load = enable && s_axis_tvalid && ld;
            end
            StPayload: begin
                s_axis_tready = ld;
                beat_acc      = s_axis_tvalid && ld;
                end_pkt       = beat_acc && (s_axis_tlast || (beat_cnt_q == LastBeat));
            end
            default: ;
        endcase
    end

    // Output register stage: holds the current beat until the consumer takes it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (ld) begin
            if (hdr_load) begin
                m_axis_tdata  <= header;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b0;
                m_axis_tuser  <= 1'b0;
            end else if (beat_acc) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= s_axis_tlast || (beat_cnt_q == LastBeat);
                m_axis_tuser  <= s_axis_tlast;
            end else begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tuser  <= 1'b0;
            end
        end
    end

    // Payload beat counter within the current packet.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_q <= '0;
        end else if (hdr_load) begin
            beat_cnt_q <= '0;
        end else if (beat_acc) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    // Sequence, chirp and packet counters; a clear pulse overrides any increment.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seq_q     <= '0;
            chirp_q   <= '0;
            pkt_count <= '0;
        end else if (clear_counters) begin
            seq_q     <= '0;
            chirp_q   <= '0;
            pkt_count <= '0;
        end else begin
            if (hdr_load) begin
                seq_q     <= seq_q + 16'd1;
                pkt_count <= pkt_count + 32'd1;
            end
            if (end_pkt && s_axis_tlast) begin
                chirp_q <= chirp_q + 16'd1;
            end
        end
    end

    // First-packet-of-chirp flag: set by a packet that ended a chirp, cleared otherwise.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            first_q <= 1'b1;
        end else if (end_pkt) begin
            first_q <= s_axis_tlast;
        end
    end

endmodule

// File: tb/tb_adc_axis_packetizer.sv
// Bench for adc_axis_packetizer with MAX_PAYLOAD_WORDS = 4: a hand-filled vector
// table for the basic framing, a packet model for longer runs, and directed
// sequences for enable gating, mid-packet reset and counter clearing.
module tb_adc_axis_packetizer;

    localparam int unsigned MAX = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        enable = 1'b0;
    logic        clear_counters = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tuser;
    logic        m_axis_tready = 1'b1;
    logic [31:0] pkt_count;

    adc_axis_packetizer #(
        .DATA_WIDTH       (64),
        .MAX_PAYLOAD_WORDS(MAX),
        .MAGIC            (16'hA5C3)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .clear_counters(clear_counters),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count)
    );

    always #5 aclk = ~aclk;

    // {tuser, tlast, tdata} of one output beat
    typedef struct packed {
        logic        user;
        logic        last;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        bit          has_in;
        logic [63:0] in_data;
        logic        in_last;
        beat_t       exp_b;
    } vec_t;

    beat_t cap_q[$];
    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    bit          rand_ready = 1'b0;
    logic        stalled = 1'b0;
    logic [63:0] stall_data = '0;

    int unsigned mdl_seq, mdl_chirp, mdl_beat;
    bit          mdl_first;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input int unsigned seq, input int unsigned chirp,
                                        input bit first);
        return {16'hA5C3, 7'b0, first, 8'h00, 16'(chirp), 16'(seq)};
    endfunction

    function automatic logic [63:0] dw(input int unsigned i);
        return 64'hDA7A_0000_0000_0000 | 64'(i);
    endfunction

    function automatic vec_t row(input bit h, input logic [63:0] d, input logic il,
                                 input logic eu, input logic el, input logic [63:0] ed);
        vec_t v;
        v.has_in  = h;
        v.in_data = d;
        v.in_last = il;
        v.exp_b   = {eu, el, ed};
        return v;
    endfunction

    task automatic mdl_reset();
        mdl_seq   = 0;
        mdl_chirp = 0;
        mdl_beat  = 0;
        mdl_first = 1'b1;
    endtask

    // Reference packetizer: a header precedes the first word of every packet.
    task automatic mdl_push(input logic [63:0] d, input logic last);
        bit end_p;
        if (mdl_beat == 0) begin
            exp_q.push_back({1'b0, 1'b0, hdr(mdl_seq, mdl_chirp, mdl_first)});
            mdl_seq++;
        end
        end_p = last || (mdl_beat == MAX - 1);
        exp_q.push_back({last, end_p, d});
        if (end_p) begin
            mdl_beat  = 0;
            mdl_first = last;
            if (last) mdl_chirp++;
        end else begin
            mdl_beat++;
        end
    endtask

    // Present one input word and hold it until accepted. Called at posedge+1.
    task automatic send_word(input logic [63:0] d, input logic last, input int gap);
        bit acc = 1'b0;
        for (int g = 0; g < gap; g++) begin
            s_axis_tvalid = 1'b0;
            @(posedge aclk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int t = 0; t < 5000; t++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %h never accepted, required acceptance", d);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_m(input logic [63:0] d, input logic last, input int gap);
        mdl_push(d, last);
        send_word(d, last, gap);
    endtask

    task automatic wait_out();
        int t = 0;
        while (cap_q.size() < exp_q.size() && t < 20000) begin
            @(negedge aclk);
            #1;
            t++;
        end
        repeat (8) @(posedge aclk);
        #1;
    endtask

    task automatic compare_all(input string name);
        check({name, " beat_count"}, 66'(cap_q.size()), 66'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s beat%0d", name, i), cap_q[i], exp_q[i]);
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    // Random output backpressure, re-drawn each cycle after the edge.
    initial forever begin
        @(posedge aclk);
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: records accepted beats, checks stall stability.
    initial forever begin
        @(negedge aclk);
        if (aresetn) begin
            if (stalled) begin
                check("hold_stable", 66'({m_axis_tvalid, m_axis_tdata}),
                      66'({1'b1, stall_data}));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                cap_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            end
            stalled    = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[13];
        logic [63:0] h;
        int remaining, len, k;

        // Hand-computed framing of D0..D9 (tlast on D9) into packets of four.
        vt[0]  = row(0, 64'h0, 0, 0, 0, 64'hA5C3_0100_0000_0000);
        vt[1]  = row(1, 64'hDA7A_0000_0000_0000, 0, 0, 0, 64'hDA7A_0000_0000_0000);
        vt[2]  = row(1, 64'hDA7A_0000_0000_0001, 0, 0, 0, 64'hDA7A_0000_0000_0001);
        vt[3]  = row(1, 64'hDA7A_0000_0000_0002, 0, 0, 0, 64'hDA7A_0000_0000_0002);
        vt[4]  = row(1, 64'hDA7A_0000_0000_0003, 0, 0, 1, 64'hDA7A_0000_0000_0003);
        vt[5]  = row(0, 64'h0, 0, 0, 0, 64'hA5C3_0000_0000_0001);
        vt[6]  = row(1, 64'hDA7A_0000_0000_0004, 0, 0, 0, 64'hDA7A_0000_0000_0004);
        vt[7]  = row(1, 64'hDA7A_0000_0000_0005, 0, 0, 0, 64'hDA7A_0000_0000_0005);
        vt[8]  = row(1, 64'hDA7A_0000_0000_0006, 0, 0, 0, 64'hDA7A_0000_0000_0006);
        vt[9]  = row(1, 64'hDA7A_0000_0000_0007, 0, 0, 1, 64'hDA7A_0000_0000_0007);
        vt[10] = row(0, 64'h0, 0, 0, 0, 64'hA5C3_0000_0000_0002);
        vt[11] = row(1, 64'hDA7A_0000_0000_0008, 0, 0, 0, 64'hDA7A_0000_0000_0008);
        vt[12] = row(1, 64'hDA7A_0000_0000_0009, 1, 1, 1, 64'hDA7A_0000_0000_0009);

        // Reset state
        #1 aresetn = 1'b0;
        #1;
        check("rst m_tvalid", 66'(m_axis_tvalid), 66'(0));
        check("rst m_tlast", 66'(m_axis_tlast), 66'(0));
        check("rst m_tuser", 66'(m_axis_tuser), 66'(0));
        check("rst m_tdata", 66'(m_axis_tdata), 66'(0));
        check("rst s_tready", 66'(s_axis_tready), 66'(0));
        check("rst pkt_count", 66'(pkt_count), 66'(0));
        check("tkeep", 66'(m_axis_tkeep), 66'(8'hFF));
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        enable  = 1'b1;
        mdl_reset();

        // Test 1: table-driven framing
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(vt[i].exp_b);
            if (vt[i].has_in) send_word(vt[i].in_data, vt[i].in_last, 0);
        end
        wait_out();
        compare_all("t1");
        check("t1 pkt_count", 66'(pkt_count), 66'(3));
        mdl_seq   = 3;
        mdl_chirp = 1;
        mdl_first = 1'b1;
        mdl_beat  = 0;

        // Test 2: chirp ending exactly on a full packet; no empty packet follows
        for (int i = 0; i < 8; i++) send_m(dw(20 + i), i == 7, 0);
        wait_out();
        check("t2 hdr0", 66'(cap_q[0].data), 66'(64'hA5C3_0100_0001_0003));
        check("t2 hdr1", 66'(cap_q[5].data), 66'(64'hA5C3_0000_0001_0004));
        compare_all("t2");
        check("t2 pkt_count", 66'(pkt_count), 66'(5));

        // Test 3: random backpressure and bursty input over 1000 words
        rand_ready = 1'b1;
        remaining  = 1000;
        k          = 0;
        while (remaining > 0) begin
            len = $urandom_range(1, 11);
            if (len > remaining) len = remaining;
            for (int j = 0; j < len; j++) begin
                send_m(dw(1000 + k), j == len - 1, $urandom_range(0, 2));
                k++;
            end
            remaining -= len;
        end
        wait_out();
        rand_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        compare_all("t3");

        // Test 4: enable gating in IDLE, then enable dropped mid-packet
        enable        = 1'b0;
        s_axis_tdata  = dw(5000);
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (20) begin
            @(negedge aclk);
            check("t4 idle s_tready", 66'(s_axis_tready), 66'(0));
            check("t4 idle m_tvalid", 66'(m_axis_tvalid), 66'(0));
        end
        @(posedge aclk);
        #1;
        enable = 1'b1;
        h = hdr(mdl_seq, mdl_chirp, mdl_first);
        mdl_push(dw(5000), 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        check("t4 hdr valid", 66'(m_axis_tvalid), 66'(1));
        check("t4 hdr data", 66'(m_axis_tdata), 66'(h));
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        enable        = 1'b0;
        send_m(dw(5001), 1'b0, 0);
        send_m(dw(5002), 1'b1, 0);
        wait_out();
        compare_all("t4");
        enable = 1'b1;

        // Test 5a: asynchronous reset two payload beats into a packet
        send_m(dw(6000), 1'b0, 0);
        send_m(dw(6001), 1'b0, 0);
        aresetn = 1'b0;
        #1;
        check("t5 rst m_tvalid", 66'(m_axis_tvalid), 66'(0));
        check("t5 rst s_tready", 66'(s_axis_tready), 66'(0));
        check("t5 rst pkt_count", 66'(pkt_count), 66'(0));
        repeat (2) @(posedge aclk);
        #1;
        cap_q.delete();
        exp_q.delete();
        aresetn = 1'b1;
        mdl_reset();
        for (int i = 0; i < 5; i++) send_m(dw(7000 + i), i == 4, 0);
        wait_out();
        check("t5 post-rst hdr", 66'(cap_q[0].data), 66'(64'hA5C3_0100_0000_0000));
        compare_all("t5a");

        // Test 5b: clear_counters between packets restarts seq and chirp numbering
        for (int i = 0; i < 6; i++) send_m(dw(8000 + i), i == 5, 0);
        wait_out();
        compare_all("t5b");
        clear_counters = 1'b1;
        @(posedge aclk);
        #1;
        clear_counters = 1'b0;
        check("t5 clr pkt_count", 66'(pkt_count), 66'(0));
        mdl_seq   = 0;
        mdl_chirp = 0;
        send_m(dw(9000), 1'b0, 0);
        send_m(dw(9001), 1'b1, 0);
        wait_out();
        check("t5 clr hdr", 66'(cap_q[0].data), 66'(64'hA5C3_0100_0000_0000));
        compare_all("t5c");
        check("t5 clr pkt_count after", 66'(pkt_count), 66'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
